dcache_stage: RTL and testbench

//  Memory pipeline stage between the ALU stage (a_*) and write-back (c_*).

---
 rtl/dcache_stage_pkg.sv | 12 +
 rtl/dcache_stage_if.sv | 23 ++
 rtl/dcache_stage_array.sv | 56 +++++
 rtl/dcache_stage.sv | 134 +++++++++++++
 tb/tb_dcache_stage.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_stage_pkg.sv
// Shared definitions for the memory-stage data cache: FSM states and word width.
package dcache_stage_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/dcache_stage_if.sv
// Line-granular handshake between the data cache and main memory.
interface dcache_stage_if #(
  parameter int WORDS = 4
) ();

  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [32*WORDS-1:0]   mem_wdata;
  logic                  mem_ack;
  logic [32*WORDS-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/dcache_stage_array.sv
// Direct-mapped cache storage: async read of one line, sync word write and line fill.
module dcache_array
  import dcache_stage_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4,
  parameter int TAG_W = 26
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(LINES)-1:0]    idx,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [XLEN*WORDS-1:0]       rd_line,
  input  logic                        wr_en,
  input  logic [$clog2(WORDS)-1:0]    wr_off,
  input  logic [XLEN-1:0]             wr_data,
  input  logic                        fill_en,
  input  logic [TAG_W-1:0]            fill_tag,
  input  logic [XLEN*WORDS-1:0]       fill_line
);

  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [XLEN*WORDS-1:0]  data_q [LINES];

  // Only the status bits are reset; tag and data are meaningless while invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (wr_en) begin
      data_q[idx][XLEN*wr_off +: XLEN] <= wr_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_stage.sv
// Memory pipeline stage: write-back, write-allocate direct-mapped data cache with
// miss handling (evict/fill) and the register towards write-back.
module dcache_stage
  import dcache_stage_pkg::*;
#(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          a_pc,
  input  logic [31:0]          a_res,
  input  logic [31:0]          a_st_data,
  input  logic [4:0]           a_r_d_a,
  input  logic                 a_w,
  input  logic                 a_is_load,
  input  logic                 a_is_store,
  input  logic                 a_nop,
  output logic                 stall,
  output logic [31:0]          c_pc,
  output logic [31:0]          c_res,
  output logic [4:0]           c_r_d_a,
  output logic                 c_w,
  output logic                 c_nop,
  dcache_stage_if.master       mem
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = XLEN - 2 - OFF_W - IDX_W;

  logic [OFF_W-1:0]       off;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic                   rd_valid, rd_dirty;
  logic [TAG_W-1:0]       rd_tag;
  logic [XLEN*WORDS-1:0]  rd_line;
  logic                   wr_en, fill_en;
  logic                   mem_op, hit;
  logic [XLEN-1:0]        load_word;
  state_t                 state_q, state_d;

  assign off       = a_res[2 +: OFF_W];
  assign idx       = a_res[2+OFF_W +: IDX_W];
  assign tag       = a_res[XLEN-1 -: TAG_W];
  assign mem_op    = ~a_nop & (a_is_load | a_is_store);
  assign hit       = rd_valid & (rd_tag == tag);
  assign load_word = rd_line[XLEN*off +: XLEN];

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .idx       (idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_en     (wr_en),
    .wr_off    (off),
    .wr_data   (a_st_data),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (mem.mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The held a_* operands keep idx/tag stable, so the request fields stay stable until ack.
  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    wr_en         = 1'b0;
    fill_en       = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = rd_line;
    case (state_q)
      IDLE: begin
        if (mem_op && !hit) begin
          stall   = 1'b1;
          state_d = (rd_valid && rd_dirty) ? EVICT : FILL;
        end else if (mem_op && a_is_store) begin
          wr_en = 1'b1;
        end
      end
      EVICT: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_we   = 1'b1;
        mem.mem_addr = {rd_tag, idx, {(OFF_W+2){1'b0}}};
        if (mem.mem_ack) state_d = FILL;
      end
      FILL: begin
        stall        = 1'b1;
        mem.mem_req  = 1'b1;
        mem.mem_addr = {tag, idx, {(OFF_W+2){1'b0}}};
        if (mem.mem_ack) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled cycle sends a bubble to write-back; the held op completes once it hits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_pc    <= '0;
      c_res   <= '0;
      c_r_d_a <= '0;
      c_w     <= 1'b0;
      c_nop   <= 1'b1;
    end else if (stall) begin
      c_w     <= 1'b0;
      c_nop   <= 1'b1;
    end else begin
      c_pc    <= a_pc;
      c_res   <= (mem_op && a_is_load) ? load_word : a_res;
      c_r_d_a <= a_r_d_a;
      c_w     <= a_w & ~a_nop & ~(mem_op & a_is_store);
      c_nop   <= a_nop;
    end
  end

endmodule

// File: tb/tb_dcache_stage.sv
// Randomized bench for dcache_stage against an architectural memory model plus a
// line-occupancy model that predicts misses, evictions and request addresses.
module tb_dcache_stage;
  import dcache_stage_pkg::*;

  localparam int LINES = 4;
  localparam int WORDS = 4;
  localparam logic [31:0] LINE_MASK = ~32'(WORDS*4 - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_pc, a_res, a_st_data;
  logic [4:0]  a_r_d_a;
  logic        a_w, a_is_load, a_is_store, a_nop;
  logic        stall;
  logic [31:0] c_pc, c_res;
  logic [4:0]  c_r_d_a;
  logic        c_w, c_nop;

  dcache_stage_if #(.WORDS(WORDS)) mem_bus ();

  dcache_stage #(.LINES(LINES), .WORDS(WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_pc       (a_pc),
    .a_res      (a_res),
    .a_st_data  (a_st_data),
    .a_r_d_a    (a_r_d_a),
    .a_w        (a_w),
    .a_is_load  (a_is_load),
    .a_is_store (a_is_store),
    .a_nop      (a_nop),
    .stall      (stall),
    .c_pc       (c_pc),
    .c_res      (c_res),
    .c_r_d_a    (c_r_d_a),
    .c_w        (c_w),
    .c_nop      (c_nop),
    .mem        (mem_bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Architectural view (latest value of every word) and the memory behind the cache.
  logic [31:0] arch    [logic [31:0]];
  logic [31:0] mem_img [logic [31:0]];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [31:0] m_base  [LINES];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_word(a);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_img.exists(a) ? mem_img[a] : init_word(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_base[i]  = '0;
    end
    arch = mem_img;
  endtask

  // Drives one instruction, plays main memory during any miss, checks the result.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] res,
                               input logic [31:0] st, input logic [4:0] rd,
                               input logic w, input logic ld, input logic sv,
                               input logic nop, input int delay, input bit stray);
    logic [31:0] waddr, base, exp_addr, cur_addr, exp_res;
    int          idx, n_req, req_seen, cycles, wait_cnt;
    bit          is_mem, miss, evict, pending, exp_we;

    a_pc = pc; a_res = res; a_st_data = st; a_r_d_a = rd;
    a_w = w; a_is_load = ld; a_is_store = sv; a_nop = nop;

    waddr    = res & ~32'h3;
    base     = res & LINE_MASK;
    idx      = int'((res >> $clog2(WORDS*4)) % LINES);
    is_mem   = !nop && (ld || sv);
    miss     = is_mem && !(m_valid[idx] && m_base[idx] == base);
    evict    = miss && m_valid[idx] && m_dirty[idx];
    n_req    = miss ? (evict ? 2 : 1) : 0;
    req_seen = 0;
    cycles   = 0;
    pending  = 0;
    wait_cnt = 0;
    cur_addr = '0;

    forever begin
      @(negedge clk);
      mem_bus.mem_ack = 1'b0;
      if (cycles == 0) begin
        checkOutput("stall_on_issue", stall, miss);
        if (stray && !miss) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = {WORDS{$urandom}};
        end
      end else begin
        checkOutput("bubble_nop", c_nop, 1'b1);
      end
      if (!stall) break;
      if (mem_bus.mem_req) begin
        if (!pending) begin
          if (req_seen >= n_req) checkOutput("extra_request", 32'(req_seen), 32'(n_req));
          exp_we   = evict && (req_seen == 0);
          exp_addr = exp_we ? m_base[idx] : base;
          checkOutput("req_we", mem_bus.mem_we, exp_we);
          checkOutput("req_addr", mem_bus.mem_addr, exp_addr);
          if (mem_bus.mem_we)
            for (int k = 0; k < WORDS; k++)
              checkOutput("evict_word", mem_bus.mem_wdata[32*k +: 32], arch_rd(m_base[idx] + 32'(4*k)));
          cur_addr = mem_bus.mem_addr;
          pending  = 1;
          wait_cnt = (delay < 0) ? int'($urandom_range(0, 3)) : delay;
          req_seen++;
        end else begin
          checkOutput("req_addr_stable", mem_bus.mem_addr, cur_addr);
        end
        if (pending && wait_cnt == 0) begin
          for (int k = 0; k < WORDS; k++) begin
            if (mem_bus.mem_we) mem_img[cur_addr + 32'(4*k)] = mem_bus.mem_wdata[32*k +: 32];
            else mem_bus.mem_rdata[32*k +: 32] = mem_rd(cur_addr + 32'(4*k));
          end
          mem_bus.mem_ack = 1'b1;
          pending = 0;
        end else if (pending) begin
          wait_cnt--;
        end
      end else if (cycles > 0) begin
        checkOutput("req_active", mem_bus.mem_req, 1'b1);
      end
      cycles++;
      if (cycles > 40) begin
        checkOutput("miss_timeout", 32'(cycles), 32'd40);
        break;
      end
    end
    checkOutput("req_count", 32'(req_seen), 32'(n_req));

    @(posedge clk);
    #1;
    mem_bus.mem_ack = 1'b0;
    exp_res = (is_mem && ld) ? arch_rd(waddr) : res;
    checkOutput("c_nop", c_nop, nop);
    checkOutput("c_w", c_w, w && !nop && !(is_mem && sv));
    checkOutput("c_pc", c_pc, pc);
    checkOutput("c_r_d_a", 32'(c_r_d_a), 32'(rd));
    checkOutput("c_res", c_res, exp_res);

    if (miss) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_base[idx]  = base;
    end
    if (is_mem && sv) begin
      arch[waddr]  = st;
      m_dirty[idx] = 1'b1;
    end
  endtask

  // Starts a cold load, waits for its fill request, then pulls reset mid-transfer.
  task automatic reset_during_fill(input logic [31:0] addr);
    bit seen = 0;
    a_pc = 32'h0000_0500; a_res = addr; a_st_data = '0; a_r_d_a = 5'd9;
    a_w = 1'b1; a_is_load = 1'b1; a_is_store = 1'b0; a_nop = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_bus.mem_req && !mem_bus.mem_we) seen = 1;
    end
    checkOutput("fill_started", seen, 1'b1);
    reset = 1'b1;
    a_nop = 1'b1;
    #1;
    checkOutput("rst_mem_req", mem_bus.mem_req, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_c_nop", c_nop, 1'b1);
    checkOutput("rst_c_w", c_w, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_models();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired: got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addr;
    int          kind;

    reset = 1'b1;
    a_pc = '0; a_res = '0; a_st_data = '0; a_r_d_a = '0;
    a_w = 1'b0; a_is_load = 1'b0; a_is_store = 1'b0; a_nop = 1'b1;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    clear_models();

    #12;
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_c_nop", c_nop, 1'b1);
    checkOutput("reset_c_w", c_w, 1'b0);
    checkOutput("reset_c_pc", c_pc, 32'h0);
    checkOutput("reset_c_res", c_res, 32'h0);
    checkOutput("reset_c_r_d_a", 32'(c_r_d_a), 32'h0);
    checkOutput("reset_mem_req", mem_bus.mem_req, 1'b0);
    checkOutput("reset_mem_we", mem_bus.mem_we, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed sequence");
    applyStimulus(32'h100, 32'd42, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t1_c_res", c_res, 32'd42);

    mem_img[32'h44] = 32'h0000_DEAD;
    arch[32'h44]    = 32'h0000_DEAD;
    applyStimulus(32'h104, 32'h40, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    applyStimulus(32'h108, 32'h44, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    checkOutput("t2_dead", c_res, 32'h0000_DEAD);

    applyStimulus(32'h10C, 32'h40, 32'h1234, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    applyStimulus(32'h110, 32'h40, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t3_store_load", c_res, 32'h1234);

    applyStimulus(32'h114, 32'h100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    applyStimulus(32'h118, 32'h104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("t4_evicted_word0", mem_rd(32'h40), 32'h1234);

    reset_during_fill(32'h210);
    applyStimulus(32'h11C, 32'h210, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0);
    applyStimulus(32'h120, 32'h3F0, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0);

    $display("[TB] random sequence");
    for (int n = 0; n < 300; n++) begin
      addr = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, LINES-1)) << 4)
           | (32'($urandom_range(0, WORDS-1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr[31] = 1'b1;
      kind = int'($urandom_range(0, 9));
      if (kind <= 3)
        applyStimulus($urandom, addr, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, -1,
                      $urandom_range(0, 7) == 0);
      else if (kind <= 6)
        applyStimulus($urandom, addr, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b1, 1'b0, -1,
                      $urandom_range(0, 7) == 0);
      else if (kind <= 8)
        applyStimulus($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, -1,
                      $urandom_range(0, 3) == 0);
      else
        applyStimulus($urandom, addr, $urandom, 5'($urandom), 1'b1, 1'($urandom), 1'b1, 1'b1, -1,
                      1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
